// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: arbitrates memory waits, taken branches, load-use
// hazards and jumps into same-cycle PC/IF-ID/ID-EX/EX-MEM control, with perf counters.
module hazard_stall_ctrl #(
  parameter int unsigned RA_W         = 5,
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  ID_rs,
  input  logic [RA_W-1:0]  ID_rt,
  input  logic             ID_uses_rt,
  input  logic             ID_jump,
  input  logic             EX_MemRead,
  input  logic [RA_W-1:0]  EX_rt,
  input  logic             EX_branch_taken,
  input  logic             MEM_req,
  input  logic             MEM_ready,
  output logic             pc_write_en,
  output logic             stall,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             hold_IDEX,
  output logic             hold_EXMEM,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned       WAIT_W    = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [0:0] {
    StRun,
    StMemWait
  } state_e;

  state_e            fsm_q, fsm_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

  logic wait_expired;
  logic freeze;
  logic load_use;
  logic timeout;

  // On the last permitted wait cycle the freeze is dropped so the pipeline can move on.
  assign wait_expired = (fsm_q == StMemWait) && (wait_cnt_q == WAIT_LAST);
  assign freeze       = MEM_req && !MEM_ready && !wait_expired;

  assign load_use = EX_MemRead && (EX_rt != '0) &&
                    ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

  always_comb begin
    fsm_d      = fsm_q;
    wait_cnt_d = wait_cnt_q;
    timeout    = 1'b0;
    case (fsm_q)
      StRun: begin
        if (freeze) begin
          fsm_d      = StMemWait;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      StMemWait: begin
        if (MEM_ready) begin
          fsm_d      = StRun;
          wait_cnt_d = '0;
        end else if (wait_expired) begin
          timeout    = 1'b1;
          fsm_d      = StRun;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        fsm_d      = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Strict priority: memory freeze, taken branch, load-use bubble, jump squash.
  always_comb begin
    pc_write_en = 1'b1;
    stall       = 1'b0;
    flush_IFID  = 1'b0;
    flush_IDEX  = 1'b0;
    hold_IDEX   = 1'b0;
    hold_EXMEM  = 1'b0;
    mem_timeout = 1'b0;
    if (reset) begin
      pc_write_en = 1'b0;
    end else begin
      mem_timeout = timeout;
      if (freeze) begin
        pc_write_en = 1'b0;
        stall       = 1'b1;
        hold_IDEX   = 1'b1;
        hold_EXMEM  = 1'b1;
      end else if (EX_branch_taken) begin
        flush_IFID  = 1'b1;
        flush_IDEX  = 1'b1;
      end else if (load_use) begin
        pc_write_en = 1'b0;
        stall       = 1'b1;
        flush_IDEX  = 1'b1;
      end else if (ID_jump) begin
        flush_IFID  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= StRun;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      wait_cnt_q <= wait_cnt_d;
      if (stall && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_IFID && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
